// File: rtl/router_pkg.sv
// router_pkg: shared defaults, tagged-entry type and header length helper for the router FIFO
package router_pkg;
    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int LEN_LSB_DEF  = 2;
    localparam int AFULL_TH_DEF = 14;

    typedef struct packed {
        logic                  hdr;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    function automatic logic [DATA_W_DEF-LEN_LSB_DEF-1:0] hdr_len(input logic [DATA_W_DEF-1:0] d);
        return d[DATA_W_DEF-1:LEN_LSB_DEF];
    endfunction
endpackage

// File: rtl/router_pkt_fifo_if.sv
// router_pkt_fifo_if: write/read handshake and status bundle of the packet FIFO
interface router_pkt_fifo_if #(
    parameter int DATA_W = router_pkg::DATA_W_DEF,
    parameter int DEPTH  = router_pkg::DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              wr_en;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              pkt_busy;
    logic              pkt_end;
    logic              pkt_err;

    modport master (
        output wr_en, lfd_state, data_in, rd_en,
        input  data_out, empty, full, almost_full, count, pkt_busy, pkt_end, pkt_err
    );
    modport slave (
        input  wr_en, lfd_state, data_in, rd_en,
        output data_out, empty, full, almost_full, count, pkt_busy, pkt_end, pkt_err
    );
endinterface

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: tagged-entry storage with one write port, a registered data read and a header look-ahead
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LEN_LSB = LEN_LSB_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clr,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W:0]            wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W:LEN_LSB]      head,
    output logic [DATA_W-1:0]          rdata
);
    logic [DATA_W:0] mem [DEPTH];

    // storage array, no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read data, cleared together with the FIFO state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rdata <= '0;
        else if (clr) rdata <= '0;
        else if (re) rdata <= mem[raddr][DATA_W-1:0];
    end

    // tag and length field of the entry about to be read
    assign head = mem[raddr][DATA_W:LEN_LSB];
endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware synchronous FIFO with occupancy flags and packet framing checks
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LEN_LSB  = LEN_LSB_DEF,
    parameter int AFULL_TH = AFULL_TH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             soft_reset,
    router_pkt_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = DATA_W - LEN_LSB;
    localparam int RW = (LW + 1 > 7) ? LW + 1 : 7;

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        cnt;
    logic [RW-1:0]        rem_cnt;
    logic                 pkt_end_q;
    logic                 pkt_err_q;
    logic                 empty_c;
    logic                 full_c;
    logic                 do_wr;
    logic                 do_rd;
    logic [DATA_W:LEN_LSB] head;
    logic [DATA_W-1:0]    rdata;

    assign empty_c = cnt == '0;
    assign full_c  = cnt == CW'(DEPTH);
    assign do_wr   = bus.wr_en && !full_c && !soft_reset;
    assign do_rd   = bus.rd_en && !empty_c && !soft_reset;

    router_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_LSB(LEN_LSB)) u_mem (
        .clk   (clk),
        .resetn(resetn),
        .clr   (soft_reset),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata ({bus.lfd_state, bus.data_in}),
        .re    (do_rd),
        .raddr (rd_ptr),
        .head  (head),
        .rdata (rdata)
    );

    // pointers wrap naturally; occupancy is tracked explicitly so full and empty never alias
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    // packet framing: headers load payload+parity, bytes count down, misframed bytes latch the error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_cnt   <= '0;
            pkt_end_q <= 1'b0;
            pkt_err_q <= 1'b0;
        end else if (soft_reset) begin
            rem_cnt   <= '0;
            pkt_end_q <= 1'b0;
            pkt_err_q <= 1'b0;
        end else begin
            pkt_end_q <= do_rd && !head[DATA_W] && rem_cnt == RW'(1);
            if (do_rd) begin
                if (head[DATA_W]) rem_cnt <= RW'(head[DATA_W-1:LEN_LSB]) + RW'(1);
                else if (rem_cnt != '0) rem_cnt <= rem_cnt - RW'(1);
                if (head[DATA_W] ? rem_cnt != '0 : rem_cnt == '0) pkt_err_q <= 1'b1;
            end
        end
    end

    assign bus.data_out    = rdata;
    assign bus.empty       = empty_c;
    assign bus.full        = full_c;
    assign bus.almost_full = cnt >= CW'(AFULL_TH);
    assign bus.count       = cnt;
    assign bus.pkt_busy    = rem_cnt != '0;
    assign bus.pkt_end     = pkt_end_q;
    assign bus.pkt_err     = pkt_err_q;
endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised, packet-aware synchronous FIFO for the router's per-destination output buffers. Each entry stores a data byte plus a header tag taken from lfd_state. On reading a header, the block loads the packet's remaining byte count from the header length field and tracks the packet until its parity byte is read. It adds occupancy count, almost-full, an end-of-packet strobe and malformed-packet detection.

Parameters:
DATA_W, 8, data width; header length field is data[DATA_W-1:LEN_LSB]
DEPTH, 16, entries; power of 2, at least 4
LEN_LSB, 2, LSB of payload-length field in header byte
AFULL_TH, 14, almost_full asserted when count >= AFULL_TH; must be less than DEPTH

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous flush; router timeout per destination
wr_en  in  1  write request
lfd_state  in  1  tags data_in as packet header
data_in  in  DATA_W  write data
rd_en  in  1  read request
data_out  out  DATA_W  registered read data
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_TH
count  out  $clog2(DEPTH)+1  current occupancy
pkt_busy  out  1  remaining-byte counter non-zero
pkt_end  out  1  one-cycle pulse, last byte of packet on data_out
pkt_err  out  1  sticky malformed-packet flag

Behaviour:
- Reset (resetn low, async): pointers, count, rem_cnt, data_out, pkt_end and pkt_err all 0. Gives empty=1, full=0, almost_full=0, pkt_busy=0.
- soft_reset (sync): same clearing on the next edge. Overrides wr_en and rd_en in that cycle.
- Write: when wr_en && !full, store {lfd_state, data_in} at wr_ptr and increment wr_ptr. When full, the write is dropped with no state change.
- Read: when rd_en && !empty, data_out <= mem[rd_ptr] data bits on the same edge (1-cycle latency) and rd_ptr increments. When empty, the read is ignored and data_out holds.
- data_out holds its last value whenever no read occurs.
- Simultaneous rd and wr:
  - Neither empty nor full: both occur and count is unchanged.
  - Empty: only the write occurs.
  - Full: only the read occurs. The write is dropped, with no bypass.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked explicitly; flags derive combinationally from count.
- Packet tracking (rem_cnt, 7-bit minimum, sized for field+1):
  - Read of a tagged entry: rem_cnt <= data[DATA_W-1:LEN_LSB] + 1 (payload plus parity).
  - Read of an untagged entry while rem_cnt > 0: rem_cnt decrements.
  - When rem_cnt goes 1 -> 0, pkt_end = 1 for that cycle, aligned with data_out.
  - Read of an untagged entry while rem_cnt == 0: pkt_err set (orphan byte); data is still delivered.
  - Read of a tagged entry while rem_cnt > 0: pkt_err set (truncated packet), and rem_cnt reloads from the new header.
  - A header with length field 0 loads rem_cnt = 1 (parity only).
  - pkt_busy = (rem_cnt != 0).
- pkt_err clears only on resetn or soft_reset.
- Async reset mid-packet: all state is lost immediately and no pkt_end is generated.

Decomposition:
- Shared package router_pkg holds:
  - default DATA_W, DEPTH and LEN_LSB constants;
  - function hdr_len(data) returning the length field;
  - typedef for the tagged entry {hdr, data}.
- One sub-module, router_fifo_mem: DEPTH x (DATA_W+1) register array with one write port and a registered read port.
- Pointers, count, flags and the packet counter live in router_pkt_fifo.

Test Plan:
- Packet read: write header 8'h0C (lfd_state=1), payload 8'h11, 8'h22, 8'h33, parity 8'h5A, then read 5.
  - data_out sequence: 0C, 11, 22, 33, 5A.
  - pkt_busy is 1 after the first read.
  - pkt_end pulses once with data_out=5A; pkt_err stays 0.
- Full/almost_full: 16 writes of 8'h00..8'h0F.
  - almost_full rises after the 14th write; full=1 and count=16 after the 16th.
  - A 17th write of 8'hFF is dropped.
  - Reading 16 returns 00..0F, then empty=1.
- Wrap-around and simultaneous access:
  - Write 12, read 12, then write 12 (pointers wrap); readback is in order.
  - At count=5, assert wr and rd together for 4 cycles: count stays 5 and order is preserved.
  - At full, rd+wr gives count=15 and the new byte is lost.
- Malformed packets:
  - Header 8'h08 (len 2), one payload byte, then a new header 8'h04.
    - pkt_err=1 on reading the second header; rem_cnt reloads to 2.
    - A subsequent untagged read after packet completion keeps pkt_err=1.
  - Header 8'h00 (len 0) then one byte: rem_cnt loads 1 and pkt_end pulses on the parity byte.
- Soft reset: mid-packet with count=3 and pkt_err=1, pulse soft_reset for one cycle with wr_en=1 asserted.
  - Next edge: count=0, empty=1, pkt_busy=0, pkt_err=0, data_out=0; the concurrent write is not stored.
- Async reset: drop resetn between clock edges during a read burst.
  - All outputs go to reset values without waiting for clk.
  - After release, the first write/read pair returns the written value with 1-cycle latency.
